// File: rtl/mem_arbiter.sv
// Two-port read/write arbiter in front of a single backing memory: port A fetches, port B loads/stores.
// Fixed priority to B on a tie by default; define MEM_ARBITER_ROUND_ROBIN_EN to alternate instead.
module mem_arbiter #(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_read,
    input  logic [width-1:0]     a_address,
    output logic [width-1:0]     a_rdata,
    output logic                 a_resp,

    input  logic                 b_read,
    input  logic                 b_write,
    input  logic [width-1:0]     b_address,
    input  logic [width-1:0]     b_wdata,
    input  logic [width/8-1:0]   b_wmask,
    output logic [width-1:0]     b_rdata,
    output logic                 b_resp,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width-1:0]     mem_address,
    output logic [width-1:0]     mem_wdata,
    output logic [width/8-1:0]   mem_wmask,
    input  logic [width-1:0]     mem_rdata,
    input  logic                 mem_resp
);

    localparam int MASK_W = width / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                mem_read_reg, mem_read_next;
    logic                mem_write_reg, mem_write_next;
    logic [width-1:0]    mem_address_reg, mem_address_next;
    logic [width-1:0]    mem_wdata_reg, mem_wdata_next;
    logic [MASK_W-1:0]   mem_wmask_reg, mem_wmask_next;

    logic                a_pending;
    logic                b_pending;
    logic                grant_a;
    logic                grant_b;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Set when B holds the most recent grant; reset leaves A as last so B wins the first tie.
    logic                last_b_reg, last_b_next;
`endif

    assign a_pending = a_read;
    assign b_pending = b_read | b_write;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_pending && b_pending) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            grant_a = last_b_reg;
            grant_b = ~last_b_reg;
`else
            grant_b = 1'b1;
`endif
        end else begin
            grant_a = a_pending;
            grant_b = b_pending;
        end
    end

    // Command fields are captured once at the grant edge and held until the memory answers.
    always_comb begin
        state_next       = state_reg;
        mem_read_next    = mem_read_reg;
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;
        mem_wmask_next   = mem_wmask_reg;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_b_next      = last_b_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_a) begin
                    state_next       = SERVE_A;
                    mem_read_next    = 1'b1;
                    mem_write_next   = 1'b0;
                    mem_address_next = a_address;
                    mem_wdata_next   = '0;
                    mem_wmask_next   = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_b_next      = 1'b0;
`endif
                end else if (grant_b) begin
                    // A simultaneous read+write request is serviced as a write.
                    state_next       = SERVE_B;
                    mem_read_next    = ~b_write;
                    mem_write_next   = b_write;
                    mem_address_next = b_address;
                    mem_wdata_next   = b_wdata;
                    mem_wmask_next   = b_wmask;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_b_next      = 1'b1;
`endif
                end
            end
            SERVE_A, SERVE_B: begin
                if (mem_resp) begin
                    state_next     = IDLE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            mem_wmask_reg   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_b_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            mem_read_reg    <= mem_read_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
            mem_wmask_reg   <= mem_wmask_next;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_b_reg      <= last_b_next;
`endif
        end
    end

    // Completion is combinational from mem_resp; a response while IDLE belongs to nobody.
    assign a_resp = (state_reg == SERVE_A) && mem_resp;
    assign b_resp = (state_reg == SERVE_B) && mem_resp;

    generate
        for (genvar gi = 0; gi < width; gi++) begin : g_rdata_gate
            assign a_rdata[gi] = mem_rdata[gi] & a_resp;
            assign b_rdata[gi] = mem_rdata[gi] & b_resp;
        end
    endgenerate

    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_wmask   = mem_wmask_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized rounds against a transaction-level model.
// Tie-break expectations follow MEM_ARBITER_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int MW = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_read;
    logic [W-1:0]  a_address;
    logic [W-1:0]  a_rdata;
    logic          a_resp;
    logic          b_read;
    logic          b_write;
    logic [W-1:0]  b_address;
    logic [W-1:0]  b_wdata;
    logic [MW-1:0] b_wmask;
    logic [W-1:0]  b_rdata;
    logic          b_resp;
    logic          mem_read;
    logic          mem_write;
    logic [W-1:0]  mem_address;
    logic [W-1:0]  mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [W-1:0]  mem_rdata;
    logic          mem_resp;

    mem_arbiter #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .a_read(a_read), .a_address(a_address), .a_rdata(a_rdata), .a_resp(a_resp),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
        .b_wmask(b_wmask), .b_rdata(b_rdata), .b_resp(b_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Transaction-level model: outstanding requests and the last port granted (0 = A, 1 = B).
    bit            pend_a, pend_b;
    logic [W-1:0]  q_a_addr;
    bit            q_b_rd, q_b_wr;
    logic [W-1:0]  q_b_addr, q_b_wdata;
    logic [MW-1:0] q_b_wmask;
    int            last_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (pend_a && !pend_b) return 0;
        if (pend_b && !pend_a) return 1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        return (last_grant == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic post_a(input logic [W-1:0] addr);
        a_read = 1'b1; a_address = addr;
        pend_a = 1'b1; q_a_addr = addr;
    endtask

    task automatic post_b(input bit rd, input bit wr, input logic [W-1:0] addr,
                          input logic [W-1:0] wd, input logic [MW-1:0] wm);
        b_read = rd; b_write = wr; b_address = addr; b_wdata = wd; b_wmask = wm;
        pend_b = 1'b1; q_b_rd = rd; q_b_wr = wr; q_b_addr = addr; q_b_wdata = wd; q_b_wmask = wm;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".mem_read"},  mem_read,  0);
        check({tag, ".mem_write"}, mem_write, 0);
        check({tag, ".a_resp"},    a_resp,    0);
        check({tag, ".b_resp"},    b_resp,    0);
        check({tag, ".a_rdata"},   a_rdata,   0);
        check({tag, ".b_rdata"},   b_rdata,   0);
    endtask

    task automatic check_cmd(input int w, input string tag);
        if (w == 0) begin
            check({tag, ".A.mem_read"},  mem_read,    1);
            check({tag, ".A.mem_write"}, mem_write,   0);
            check({tag, ".A.mem_addr"},  mem_address, q_a_addr);
            check({tag, ".A.mem_wdata"}, mem_wdata,   0);
            check({tag, ".A.mem_wmask"}, mem_wmask,   0);
        end else begin
            check({tag, ".B.mem_read"},  mem_read,    (q_b_rd && !q_b_wr));
            check({tag, ".B.mem_write"}, mem_write,   q_b_wr);
            check({tag, ".B.mem_addr"},  mem_address, q_b_addr);
            check({tag, ".B.mem_wdata"}, mem_wdata,   q_b_wdata);
            check({tag, ".B.mem_wmask"}, mem_wmask,   q_b_wmask);
        end
    endtask

    // Serves everything outstanding; called right after requests are posted while the DUT is idle.
    task automatic serve(input int lat_lo, input int lat_hi, input bit mid_change, input bit stray,
                         input bit fix, input logic [W-1:0] fixv);
        int w;
        int lat;
        logic [W-1:0] rdv;
        while (pend_a || pend_b) begin
            w   = pick();
            lat = $urandom_range(lat_hi, lat_lo);
            rdv = fix ? fixv : W'($urandom);
            @(posedge clk); #1;
            mem_resp = 1'b0;
            @(negedge clk);
            for (int i = 1; i <= lat; i++) begin
                if (i > 1) @(negedge clk);
                check_cmd(w, "cmd");
                if (i == lat) begin
                    mem_rdata = rdv; mem_resp = 1'b1;
                end else begin
                    mem_rdata = W'($urandom);
                end
                #1;
                check("a_resp",  a_resp,  (i == lat && w == 0));
                check("b_resp",  b_resp,  (i == lat && w == 1));
                check("a_rdata", a_rdata, (i == lat && w == 0) ? rdv : '0);
                check("b_rdata", b_rdata, (i == lat && w == 1) ? rdv : '0);
                if (mid_change && i == 1) begin
                    if (w == 0) a_address = q_a_addr ^ 32'h0000_3000;
                    else begin
                        b_address = q_b_addr ^ 32'h0000_3000;
                        b_wdata   = ~q_b_wdata;
                        b_wmask   = ~q_b_wmask;
                    end
                end
            end
            last_grant = w;
            @(posedge clk); #1;
            mem_resp  = 1'b0;
            mem_rdata = W'($urandom);
            if (w == 0) begin a_read = 1'b0; pend_a = 1'b0; end
            else begin b_read = 1'b0; b_write = 1'b0; pend_b = 1'b0; end
            txn++;
            $display("txn %0d: port %s lat=%0d rdata=%08h", txn, (w == 0) ? "A" : "B", lat, rdv);
            @(negedge clk);
            check_idle("gap");
            if (stray) begin
                mem_resp = 1'b1; mem_rdata = W'($urandom);
                #1;
                check("stray.a_resp", a_resp, 0);
                check("stray.b_resp", b_resp, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_read = 0; a_address = '0;
        b_read = 0; b_write = 0; b_address = '0; b_wdata = '0; b_wmask = '0;
        mem_rdata = '0; mem_resp = 0;
        pend_a = 0; pend_b = 0; last_grant = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.mem_addr",  mem_address, 0);
        check("rst.mem_wdata", mem_wdata,   0);
        check("rst.mem_wmask", mem_wmask,   0);
        check_idle("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // Single A read, three-cycle memory latency.
        post_a(32'h0000_1000);
        serve(3, 3, 0, 0, 1, 32'hDEAD_BEEF);

        // B masked write, then B read+write collapsing into a write.
        post_b(0, 1, 32'h0000_0040, 32'h1234_5678, 4'b0011);
        serve(2, 2, 0, 0, 0, '0);
        post_b(1, 1, 32'h0000_0080, 32'hCAFE_F00D, 4'b1111);
        serve(1, 1, 0, 1, 0, '0);

        // Simultaneous requests after a B grant, then after an A grant.
        post_a(32'h0000_0100);
        post_b(1, 0, 32'h0000_0200, 32'h0, 4'b0000);
        serve(1, 1, 0, 0, 0, '0);
        post_a(32'h0000_0300);
        serve(1, 1, 0, 0, 0, '0);
        post_a(32'h0000_0400);
        post_b(0, 1, 32'h0000_0500, 32'h5555_AAAA, 4'b1010);
        serve(1, 1, 0, 0, 0, '0);

        // Address change while A is being served must not disturb the command.
        post_a(32'h0000_1000);
        serve(3, 3, 1, 0, 0, '0);

        // Reset during SERVE_B followed by a stray memory response.
        mem_resp = 1'b0;
        post_b(0, 1, 32'h0000_0600, 32'h0BAD_F00D, 4'b0110);
        @(posedge clk); #1;
        @(negedge clk);
        check_cmd(1, "rst_serve");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; b_write = 1'b0; b_read = 1'b0; pend_b = 1'b0; last_grant = 0;
        mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("rst_serve.mem_addr",  mem_address, 0);
        check("rst_serve.mem_wdata", mem_wdata,   0);
        check("rst_serve.mem_wmask", mem_wmask,   0);
        check_idle("rst_serve");
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        check_idle("rst_serve2");

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            int kind;
            bit pa;
            pa   = 1'($urandom);
            kind = $urandom_range(3, 0);
            if (!pa && kind == 0) pa = 1'b1;
            if (pa) post_a(W'($urandom));
            if (kind != 0)
                post_b(kind[0], kind[1], W'($urandom), W'($urandom), MW'($urandom));
            serve(1, 4, 1'($urandom), 1'($urandom), 0, '0);
        end

        mem_resp = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter width, default 32, data and address width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a_read  input  1  port A (fetch) read request, held until a_resp.
REQ-005 SHALL have port a_address  input  width  port A address.
REQ-006 SHALL have port a_rdata / a_resp  output  width / 1  port A read data / completion pulse.
REQ-007 SHALL have port b_read, b_write  input  1 each  port B (data) request, held until b_resp.
REQ-008 SHALL have port b_address, b_wdata  input  width each; b_wmask  input  width/8.
REQ-009 SHALL have port b_rdata / b_resp  output  width / 1  port B read data / completion pulse.
REQ-010 SHALL have port mem_read, mem_write  output  1 each  backing-memory command.
REQ-011 SHALL have port mem_address, mem_wdata  output  width each; mem_wmask  output  width/8.
REQ-012 SHALL have port mem_rdata  input  width; mem_resp  input  1  memory completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE_A, SERVE_B.
REQ-014 IDLE, only A pending -> SERVE_A on next edge; only B pending (b_read|b_write) -> SERVE_B.
REQ-015 IDLE, both pending -> winner per REQ-027/028; loser stays pending, no resp.
REQ-016 On grant edge SHALL register granted port's address, wdata, wmask, read/write into mem_* outputs; these stay constant for the whole SERVE state.
REQ-017 b_read and b_write both high SHALL be treated as write (mem_write=1, mem_read=0).
REQ-018 Port A grant SHALL drive mem_write=0, mem_wmask=0.
REQ-019 In SERVE_x with mem_resp=1: x_resp=1 same cycle (combinational), x_rdata=mem_rdata, other port resp=0; next edge -> IDLE with mem_read=mem_write=0.
REQ-020 In SERVE_x with mem_resp=0: remain; a_resp=b_resp=0.
REQ-021 mem_resp while IDLE SHALL be ignored (no resp pulse, no state change).
REQ-022 Requester deasserting mid-SERVE SHALL NOT abort; transaction completes, resp still pulses once.
REQ-023 Minimum service: request at edge N -> mem command visible after edge N+1... i.e. from cycle N+1; one IDLE cycle mandatory between consecutive grants.
REQ-024 a_rdata/b_rdata SHALL be 0 when corresponding resp=0.
REQ-025 Exactly one mem command active at any time; mem_read&mem_write never both 1.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, mem_read=mem_write=0, mem_address=mem_wdata=mem_wmask=0, priority pointer=A-last (B favoured); in-flight transaction abandoned, its later mem_resp ignored per REQ-021.

Configuration
REQ-027 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: simultaneous requests SHALL grant the port NOT granted most recently; pointer updates at every grant.
REQ-028 Macro undefined: simultaneous requests SHALL always grant port B (fixed priority); no pointer state.

Verification
REQ-029 Single A read 0x0000_1000, mem_resp after 3 cycles with mem_rdata=0xDEAD_BEEF -> mem_read high 3 cycles, a_resp one cycle with a_rdata=0xDEAD_BEEF, b_resp=0.
REQ-030 B write addr 0x40, wdata 0x1234_5678, wmask 0b0011 -> mem_write=1, mem_address=0x40, mem_wmask=0b0011 until mem_resp; b_resp one pulse.
REQ-031 A and B asserted same cycle, both held, resp delay 1 -> without macro: B served then A; with macro after prior A grant: B then A, after prior B grant: A then B; one IDLE cycle between.
REQ-032 A served, a_address changed to 0x2000 mid-SERVE -> mem_address stays 0x1000 until mem_resp.
REQ-033 rst asserted during SERVE_B, stray mem_resp next cycle -> all mem_* outputs 0, no b_resp, FSM IDLE.
REQ-034 b_read=b_write=1 -> mem_write=1, mem_read=0.
